// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between an adder result producer/consumer and the accumulator.
// master drives samples, clear and out_ready; slave is the accumulator itself.
interface adder_result_accumulator_if #(
    parameter int NUM_SAMPLES = 16,
    parameter int ACC_WIDTH   = 16
);
    localparam int CW = $clog2(NUM_SAMPLES + 1);

    logic                 clear;
    logic                 in_valid;
    logic [7:0]           in_sum;
    logic                 in_overflow;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_acc;
    logic [CW-1:0]        out_count;
    logic                 out_wrap;

    modport master (
        output clear,
        output in_valid,
        output in_sum,
        output in_overflow,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_acc,
        input  out_count,
        input  out_wrap
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  in_sum,
        input  in_overflow,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_acc,
        output out_count,
        output out_wrap
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// Accumulates NUM_SAMPLES 9-bit adder results, holds the total until taken.
// Define ADDER_ACC_SATURATE_EN to saturate on overflow instead of wrapping.
module adder_result_accumulator #(
    parameter int NUM_SAMPLES = 16,
    parameter int ACC_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    adder_result_accumulator_if.slave    bus
);
    localparam int CW = $clog2(NUM_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 wrap_q, wrap_d;
    logic [ACC_WIDTH:0]   sum;
    logic [CW-1:0]        count_inc;

    // Extra top bit catches overflow of the running total.
    assign sum = {1'b0, acc_q}
               + (ACC_WIDTH + 1)'({bus.in_overflow, bus.in_sum});
    assign count_inc = count_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        count_d       = count_q;
        wrap_d        = wrap_q;
        bus.in_ready  = (state_q == ACCUM) && !bus.clear;
        bus.out_valid = (state_q == HOLD);
        if (bus.clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            wrap_d  = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
`ifdef ADDER_ACC_SATURATE_EN
                        acc_d = sum[ACC_WIDTH] ? '1
                              : sum[ACC_WIDTH-1:0];
`else
                        acc_d = sum[ACC_WIDTH-1:0];
`endif
                        wrap_d  = wrap_q | sum[ACC_WIDTH];
                        count_d = count_inc;
                        if (count_inc == LAST) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        count_d = '0;
                        wrap_d  = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    assign bus.out_acc   = acc_q;
    assign bus.out_count = count_q;
    assign bus.out_wrap  = wrap_q;
endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed and randomized checks of adder_result_accumulator against
// an arithmetic reference model (default instance plus a 4-sample, 10-bit one).
module tb_adder_result_accumulator;
    localparam int N  = 16;
    localparam int W  = 16;
    localparam int NO = 4;
    localparam int WO = 10;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    adder_result_accumulator_if #(.NUM_SAMPLES(N), .ACC_WIDTH(W)) ifc ();
    adder_result_accumulator_if #(.NUM_SAMPLES(NO), .ACC_WIDTH(WO)) ifo ();

    adder_result_accumulator #(.NUM_SAMPLES(N), .ACC_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    adder_result_accumulator #(.NUM_SAMPLES(NO), .ACC_WIDTH(WO)) dut_o (
        .clk (clk),
        .rst (rst),
        .bus (ifo.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_acc(input int total, input int w);
        int max;
        max = (1 << w) - 1;
        if (total <= max) return total;
`ifdef ADDER_ACC_SATURATE_EN
        return max;
`else
        return total % (1 << w);
`endif
    endfunction

    function automatic int model_wrap(input int total, input int w);
        return (total > (1 << w) - 1) ? 1 : 0;
    endfunction

    task automatic push(input logic [8:0] v);
        ifc.in_valid = 1'b1;
        {ifc.in_overflow, ifc.in_sum} = v;
        step();
    endtask

    task automatic push_o(input logic [8:0] v);
        ifo.in_valid = 1'b1;
        {ifo.in_overflow, ifo.in_sum} = v;
        step();
    endtask

    task automatic drain();
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;
        check("drain_valid", ifc.out_valid, 0);
        check("drain_acc", ifc.out_acc, 0);
        check("drain_ready", ifc.in_ready, 1);
    endtask

    task automatic rand_round();
        int total;
        int v;
        int acc0;
        total = 0;
        for (int i = 0; i < N; i++) begin
            while ($urandom_range(0, 2) == 0) begin
                ifc.in_valid = 1'b0;
                step();
            end
            v = $urandom_range(0, 511);
            push(9'(v));
            total += v;
            check("rnd_count", ifc.out_count, i + 1);
            check("rnd_valid", ifc.out_valid, (i == N - 1) ? 1 : 0);
        end
        ifc.in_valid = 1'b0;
        acc0 = model_acc(total, W);
        check("rnd_acc", ifc.out_acc, acc0);
        check("rnd_wrap", ifc.out_wrap, model_wrap(total, W));
        for (int s = $urandom_range(0, 3); s > 0; s--) begin
            ifc.in_valid = 1'($urandom_range(0, 1));
            step();
            check("rnd_stall_acc", ifc.out_acc, acc0);
            check("rnd_stall_rdy", ifc.in_ready, 0);
        end
        drain();
    endtask

    task automatic rand_round_o();
        int total;
        int v;
        total = 0;
        for (int i = 0; i < NO; i++) begin
            v = $urandom_range(200, 511);
            push_o(9'(v));
            total += v;
        end
        ifo.in_valid = 1'b0;
        check("ovr_rnd_valid", ifo.out_valid, 1);
        check("ovr_rnd_acc", ifo.out_acc, model_acc(total, WO));
        check("ovr_rnd_wrap", ifo.out_wrap, model_wrap(total, WO));
        ifo.out_ready = 1'b1;
        step();
        ifo.out_ready = 1'b0;
        check("ovr_rnd_drain", ifo.out_wrap, 0);
    endtask

    initial begin
        int cyc;
        int s1;
        int s2;
        int v;
        bit done;
        n_cmp = 0;
        n_bad = 0;
        ifc.clear = 0; ifc.in_valid = 0; ifc.in_sum = 0;
        ifc.in_overflow = 0; ifc.out_ready = 0;
        ifo.clear = 0; ifo.in_valid = 0; ifo.in_sum = 0;
        ifo.in_overflow = 0; ifo.out_ready = 0;

        // reset under random traffic
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ifc.in_valid  = 1'($urandom_range(0, 1));
            ifc.in_sum    = 8'($urandom);
            ifc.out_ready = 1'($urandom_range(0, 1));
            ifc.clear     = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0;
        ifc.in_valid = 0; ifc.out_ready = 0; ifc.clear = 0;
        #1;
        check("rst_acc", ifc.out_acc, 0);
        check("rst_count", ifc.out_count, 0);
        check("rst_wrap", ifc.out_wrap, 0);
        check("rst_valid", ifc.out_valid, 0);
        check("rst_ready", ifc.in_ready, 1);

        // basic accumulate
        for (int i = 0; i < N; i++) begin
            push(9'd10);
            check("basic_valid", ifc.out_valid, (i == N - 1) ? 1 : 0);
        end
        check("basic_acc", ifc.out_acc, 160);
        check("basic_count", ifc.out_count, 16);
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1;
            step();
            check("stall_acc", ifc.out_acc, 160);
            check("stall_count", ifc.out_count, 16);
            check("stall_valid", ifc.out_valid, 1);
            check("stall_ready", ifc.in_ready, 0);
        end
        drain();

        // carry input
        for (int i = 0; i < N; i++) push(9'h1FF);
        ifc.in_valid = 1'b0;
        check("carry_acc", ifc.out_acc, 8176);
        check("carry_wrap", ifc.out_wrap, 0);
        drain();

        // clear mid-stream
        for (int i = 0; i < 5; i++) push(9'd20);
        ifc.in_valid = 1'b1;
        {ifc.in_overflow, ifc.in_sum} = 9'd7;
        ifc.clear = 1'b1;
        #1;
        check("clear_ready", ifc.in_ready, 0);
        step();
        ifc.clear = 1'b0;
        ifc.in_valid = 1'b0;
        #1;
        check("clear_acc", ifc.out_acc, 0);
        check("clear_count", ifc.out_count, 0);
        check("clear_ready_after", ifc.in_ready, 1);
        check("clear_valid", ifc.out_valid, 0);
        for (int i = 0; i < N; i++) push(9'd1);
        ifc.in_valid = 1'b0;
        check("clear_refill", ifc.out_acc, 16);
        check("clear_refill_v", ifc.out_valid, 1);
        drain();

        // reset while holding
        for (int i = 0; i < N; i++) push(9'($urandom_range(0, 511)));
        ifc.in_valid = 1'b0;
        check("hold_before_rst", ifc.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hold_rst_valid", ifc.out_valid, 0);
        check("hold_rst_acc", ifc.out_acc, 0);
        check("hold_rst_count", ifc.out_count, 0);

        // overflow instance
        for (int i = 0; i < NO; i++) push_o(9'd511);
        ifo.in_valid = 1'b0;
`ifdef ADDER_ACC_SATURATE_EN
        check("ovf_acc", ifo.out_acc, 1023);
`else
        check("ovf_acc", ifo.out_acc, 1020);
`endif
        check("ovf_wrap", ifo.out_wrap, 1);
        check("ovf_valid", ifo.out_valid, 1);
        ifo.out_ready = 1'b1;
        step();
        ifo.out_ready = 1'b0;

        for (int r = 0; r < 3; r++) rand_round();
        for (int r = 0; r < 3; r++) rand_round_o();

        // drain/restart with continuous traffic
        cyc = 0; s1 = 0; s2 = 0; done = 0;
        ifc.out_ready = 1'b1;
        while (!done && cyc < 100) begin
            v = $urandom_range(0, 511);
            if (cyc < N) s1 += v;
            else if (cyc > N && cyc <= 2 * N) s2 += v;
            push(9'(v));
            cyc++;
            if (cyc == N) begin
                check("dr_first_valid", ifc.out_valid, 1);
                check("dr_first_acc", ifc.out_acc, s1);
            end
            if (cyc == N + 1) begin
                check("dr_xfer_valid", ifc.out_valid, 0);
                check("dr_xfer_ready", ifc.in_ready, 1);
                check("dr_xfer_count", ifc.out_count, 0);
            end
            if (cyc == N + 2) begin
                check("dr_next_count", ifc.out_count, 1);
            end
            if (ifc.out_valid && cyc > N) begin
                done = 1;
                check("dr_second_acc", ifc.out_acc, s2);
                check("dr_span", cyc + 1, 2 * (N + 1));
            end
        end
        check("dr_done", 32'(done), 1);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/adder_result_accumulator.md
# adder_result_accumulator

Block that sits directly downstream of `adder_8bit` and consumes its 9-bit result, the carry-out concatenated with the sum.
- Sums a fixed number of results into a wide accumulator, with a valid/ready handshake on both sides.
- Presents the total once the sample count is reached and holds it until the consumer takes it.
- Flags accumulator overflow as a sticky bit.

## Interface
Parameters:
- `NUM_SAMPLES`, default 16: adder results accumulated per output; legal range 1–255.
- `ACC_WIDTH`, default 16: accumulator width; legal range 9–32.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `clear`, in, 1: synchronous restart of the current accumulation.
- `in_valid`, in, 1: an adder result is presented.
- `in_sum`, in, 8: adder `sum`.
- `in_overflow`, in, 1: adder `overflow` (carry-out).
- `in_ready`, out, 1: the block accepts a sample this cycle.
- `out_valid`, out, 1: the accumulated total is available.
- `out_ready`, in, 1: the consumer takes the total.
- `out_acc`, out, ACC_WIDTH: accumulated total.
- `out_count`, out, $clog2(NUM_SAMPLES+1): number of samples accepted so far.
- `out_wrap`, out, 1: sticky flag, set when the accumulator exceeded its range.

## Operation
- Sample value is the 9-bit quantity `{in_overflow, in_sum}`, range 0–511, zero-extended to ACC_WIDTH.
- Accept condition: `in_valid && in_ready`.
- Two-state FSM:
  - ACCUM:
    - `in_ready = !clear`.
    - On each accept, acc ← acc + sample and count ← count + 1.
    - If the accept brings count to NUM_SAMPLES, go to HOLD.
  - HOLD:
    - `in_ready = 0`, `out_valid = 1`.
    - `out_acc`, `out_count` and `out_wrap` are frozen.
    - `in_valid` is ignored.
    - On `out_ready`: acc ← 0, count ← 0, wrap ← 0, go to ACCUM.
- Overflow rule:
  - The sum is formed at ACC_WIDTH+1 bits.
  - If bit ACC_WIDTH is set, wrap ← 1.
  - The stored acc follows the Configuration rule.
- `clear`:
  - In any state: acc ← 0, count ← 0, wrap ← 0, state ← ACCUM.
  - A sample presented in the same cycle is not accepted, because `in_ready` is 0.
- Priority order: `rst` > `clear` > handshake/accumulate.
- `out_valid` depends only on state (Moore).
- `in_ready` depends only on state and `clear`; it has no dependence on `in_valid`.

## Timing
- Reset values, visible the cycle after `rst` is sampled high:
  - state ACCUM
  - `out_acc` = 0, `out_count` = 0, `out_wrap` = 0
  - `out_valid` = 0, `in_ready` = 1
- Throughput: one sample per cycle in ACCUM; back-to-back accepts need no bubbles.
- Latency:
  - An accepted sample is reflected in `out_acc`/`out_count` on the next cycle.
  - If the NUM_SAMPLES-th sample is accepted in cycle k, `out_valid` = 1 in cycle k+1.
- Output handshake:
  - If `out_valid && out_ready` in cycle m, then in cycle m+1: `out_valid` = 0, `in_ready` = 1, `out_acc` = 0.
  - The earliest next accept is therefore cycle m+1, giving NUM_SAMPLES+1 cycles minimum per result.
- Stall: while `out_ready` = 0 in HOLD, all outputs hold indefinitely.
- Reset or `clear` mid-accumulation or during HOLD discards the partial or held total with no output transfer.
- NUM_SAMPLES = 1: each accepted sample moves the FSM to HOLD on the next cycle.

## Configuration
- `ADDER_ACC_SATURATE_EN` defined:
  - On overflow, acc ← {ACC_WIDTH{1'b1}} and stays saturated for the rest of the accumulation.
  - wrap ← 1.
- Not defined:
  - acc ← low ACC_WIDTH bits of the sum (modulo 2^ACC_WIDTH).
  - wrap ← 1.
- `out_wrap` behaviour is identical in both builds.

## Test plan
- Reset:
  - Stimulus: `rst` high 2 cycles during random traffic, then low.
  - Required: `out_acc` = 0, `out_count` = 0, `out_wrap` = 0, `out_valid` = 0, `in_ready` = 1.
  - Reset asserted during HOLD: `out_valid` = 0 on the next cycle.
- Basic accumulate (defaults):
  - Stimulus: 16 back-to-back samples of `{0, 8'd10}`, `out_ready` = 0.
  - Required: `out_valid` rises the cycle after the 16th accept, with `out_acc` = 160 and `out_count` = 16.
  - With `out_ready` held low for 3 cycles, outputs are stable and `in_ready` = 0.
  - `in_valid` held high during HOLD is not counted.
- Carry input:
  - Stimulus: 16 samples of `{1, 8'hFF}` (value 511).
  - Required: `out_acc` = 8176, `out_wrap` = 0.
- Overflow (ACC_WIDTH = 10, NUM_SAMPLES = 4):
  - Stimulus: 4 samples of 511.
  - Required without macro: `out_acc` = 1020, `out_wrap` = 1.
  - Required with `ADDER_ACC_SATURATE_EN`: `out_acc` = 1023, `out_wrap` = 1.
- Clear mid-stream:
  - Stimulus: 5 samples of 20, then `clear` = 1 with `in_valid` = 1 and a sample of 7.
  - Required: `in_ready` = 0 during the `clear` cycle; next cycle `out_acc` = 0, `out_count` = 0, state ACCUM.
  - The following 16 samples of 1 give `out_acc` = 16.
- Drain/restart:
  - Stimulus: `out_ready` = 1 on the first HOLD cycle, with `in_valid` = 1 continuously.
  - Required: the next sample is accepted exactly one cycle after the transfer.
  - The second result is correct and independent of the first.
  - Cycle count from first accept to second `out_valid` = 2·(NUM_SAMPLES+1).
